conv_accum_ctrl: RTL and testbench

Sequencing controller for the 9-lane MAC adder tree. It accepts streamed 9-lane product vectors from the PE array and issues them to an external `adder_tree` instance. It accumulates the tree's per-vector sums across `cfg_channels` input channels, then adds bias, shifts, applies optional ReLU and saturates. Finished output pixels are delivered through a 2-entry output FIFO with valid/ready backpressure, and the block runs one job of `cfg_pixels` outputs per `start`.

---
 rtl/conv_accum_ctrl.sv | 178 +++++++++++++++++
 tb/tb_conv_accum_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_accum_ctrl.sv
// Job sequencer for the 9-lane MAC adder tree: issues product vectors, accumulates
// per-pixel tree sums over the channel count, then bias/shift/ReLU/saturate into a 2-deep FIFO.
module conv_accum_ctrl #(
    parameter int COLUMN_WIDTH = 9,
    parameter int DATA_WIDTH   = 16,
    parameter int MAC_WIDTH    = DATA_WIDTH*2,
    parameter int OUT_WIDTH    = MAC_WIDTH+4,
    parameter int CH_BITS      = 8,
    parameter int PIX_BITS     = 16,
    parameter int ACC_WIDTH    = OUT_WIDTH+CH_BITS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [CH_BITS-1:0]                cfg_channels,
    input  logic [PIX_BITS-1:0]               cfg_pixels,
    input  logic [OUT_WIDTH-1:0]              cfg_bias,
    input  logic [4:0]                        cfg_shift,
    input  logic                              cfg_relu,
    output logic                              busy,
    output logic                              done,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [COLUMN_WIDTH*MAC_WIDTH-1:0] in_data,
    output logic [COLUMN_WIDTH*MAC_WIDTH-1:0] tree_data,
    input  logic [OUT_WIDTH-1:0]              tree_sum,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data
);

    localparam int STAGES = 2;
    localparam int RW     = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CH_BITS-1:0]  CH_ONE  = 1;
    localparam logic [PIX_BITS-1:0] PIX_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [CH_BITS-1:0]   channels;
        logic [PIX_BITS-1:0]  pixels;
        logic [OUT_WIDTH-1:0] bias;
        logic [4:0]           shift;
        logic                 relu;
    } cfg_t;

    state_t                state;
    cfg_t                  cfg;
    logic [CH_BITS-1:0]    ch_cnt;
    logic [PIX_BITS-1:0]   pix_cnt;
    logic [STAGES-1:0]     vld_pipe, first_pipe, last_pipe;
    logic signed [ACC_WIDTH-1:0] acc, acc_next, ts_ext;
    logic signed [RW-1:0]  acc_wide, bias_ext, res_shr, res_clip;
    logic [COLUMN_WIDTH-1:0][MAC_WIDTH-1:0] lane_q;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic [1:0]            fifo_cnt;
    logic                  wr_ptr, rd_ptr;
    logic                  accept, ch_last, pix_last, push, pop, drain_empty;
    logic [1:0]            fin_inflight;

    assign ch_last   = (ch_cnt == cfg.channels - CH_ONE);
    assign pix_last  = (pix_cnt == cfg.pixels - PIX_ONE);
    assign accept    = in_valid && in_ready;
    assign push      = vld_pipe[1] && last_pipe[1];
    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_mem[rd_ptr];
    assign tree_data = lane_q;

    // Pixel-final vectors still in the pipe will each need a FIFO slot.
    always_comb begin
        fin_inflight = {1'b0, vld_pipe[0] & last_pipe[0]} + {1'b0, vld_pipe[1] & last_pipe[1]};
        in_ready     = (state == RUN) && (({1'b0, fifo_cnt} + {1'b0, fin_inflight}) < 3'd2);
        drain_empty  = (vld_pipe == '0) &&
                       ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));
    end

    always_comb begin
        ts_ext   = {{(ACC_WIDTH-OUT_WIDTH){tree_sum[OUT_WIDTH-1]}}, tree_sum};
        acc_next = first_pipe[1] ? ts_ext : acc + ts_ext;
        acc_wide = {acc_next[ACC_WIDTH-1], acc_next};
        bias_ext = {{(RW-OUT_WIDTH){cfg.bias[OUT_WIDTH-1]}}, cfg.bias};
        res_shr  = (acc_wide + bias_ext) >>> cfg.shift;
        res_clip = res_shr;
        if (cfg.relu && res_shr[RW-1])
            res_clip = '0;
        else if (res_shr > SAT_MAX)
            res_clip = SAT_MAX;
        else if (res_shr < SAT_MIN)
            res_clip = SAT_MIN;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg     <= '0;
            ch_cnt  <= '0;
            pix_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cfg     <= '{cfg_channels, cfg_pixels, cfg_bias, cfg_shift, cfg_relu};
                    ch_cnt  <= '0;
                    pix_cnt <= '0;
                    busy    <= 1'b1;
                    if (cfg_channels == '0 || cfg_pixels == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: if (accept) begin
                    if (ch_last) begin
                        ch_cnt  <= '0;
                        pix_cnt <= pix_cnt + PIX_ONE;
                        if (pix_last) state <= DRAIN;
                    end else begin
                        ch_cnt <= ch_cnt + CH_ONE;
                    end
                end
                DRAIN: if (drain_empty) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0: controller register driving the tree; stage 1: tree output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
            lane_q     <= '0;
            acc        <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-2:0], accept};
            first_pipe <= {first_pipe[STAGES-2:0], ch_cnt == '0};
            last_pipe  <= {last_pipe[STAGES-2:0], ch_last};
            if (accept)      lane_q <= in_data;
            if (vld_pipe[1]) acc    <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= res_clip[DATA_WIDTH-1:0];
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_accum_ctrl.sv
// Scoreboard bench for conv_accum_ctrl with a registered adder-tree model and a
// per-pixel arithmetic reference computed when each job's stimulus is built.
module tb_conv_accum_ctrl;
    localparam int COL = 9, DW = 16, MW = 32, OW = 36, CHB = 8, PXB = 16;
    localparam int IW  = COL*MW;

    logic           clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [CHB-1:0] cfg_channels = '0;
    logic [PXB-1:0] cfg_pixels = '0;
    logic [OW-1:0]  cfg_bias = '0;
    logic [4:0]     cfg_shift = '0;
    logic           cfg_relu = 1'b0;
    logic           busy, done, in_ready, out_valid;
    logic           in_valid = 1'b0, out_ready = 1'b0;
    logic [IW-1:0]  in_data = '0, tree_data;
    logic [OW-1:0]  tree_sum = '0;
    logic [DW-1:0]  out_data;

    int     n_cmp = 0, n_fail = 0, job_accepts = 0;
    longint exp_q[$];
    bit     rnd_stop = 0;

    conv_accum_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_channels(cfg_channels), .cfg_pixels(cfg_pixels), .cfg_bias(cfg_bias),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tree_data(tree_data), .tree_sum(tree_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] tree_add(input logic [IW-1:0] d);
        logic signed [OW-1:0] s;
        s = '0;
        for (int l = 0; l < COL; l++) s += OW'($signed(d[l*MW +: MW]));
        return s;
    endfunction

    // External adder tree: one register stage.
    always @(posedge clk) tree_sum <= tree_add(tree_data);

    function automatic longint model(input longint acc, input longint bias, input int shift, input bit relu);
        longint v, d, q;
        v = acc + bias;
        d = longint'(1) << shift;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    function automatic longint lane_val(input int mode, input longint fixed);
        longint r;
        if (mode == 0) return fixed;
        case ($urandom_range(0, 3))
            0:       r = longint'($urandom_range(0, 400)) - 200;
            1:       r = longint'(int'($urandom));
            2:       r = longint'($urandom_range(0, 32'h7FFF_FFFF));
            default: r = -longint'($urandom_range(0, 65535));
        endcase
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0d, expected no output", $signed(out_data));
                end else begin
                    check("out_data", longint'($signed(out_data)), exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!done && waited < 3000);
        check({tag, "_done_seen"}, done, 1);
        if (done) begin
            check({tag, "_busy_with_done"}, busy, 1);
            @(negedge clk);
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_busy_after"}, busy, 0);
        end
        check({tag, "_all_outputs"}, exp_q.size(), 0);
    endtask

    task automatic run_job(input string tag, input int ch, input int pix, input longint bias,
                           input int shift, input bit relu, input int mode, input longint fixed,
                           input bit midstart);
        logic [IW-1:0] vecs[$];
        logic [IW-1:0] v;
        longint acc, ln;
        int waited;
        bit to;
        for (int p = 0; p < pix; p++) begin
            acc = 0;
            for (int c = 0; c < ch; c++) begin
                v = '0;
                for (int l = 0; l < COL; l++) begin
                    ln = lane_val(mode, fixed);
                    acc += ln;
                    v[l*MW +: MW] = ln[MW-1:0];
                end
                vecs.push_back(v);
            end
            if (ch > 0) exp_q.push_back(model(acc, bias, shift, relu));
        end
        @(posedge clk); #1;
        cfg_channels = ch[CHB-1:0];
        cfg_pixels   = pix[PXB-1:0];
        cfg_bias     = bias[OW-1:0];
        cfg_shift    = shift[4:0];
        cfg_relu     = relu;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        cfg_channels = CHB'($urandom);
        cfg_pixels   = PXB'($urandom);
        cfg_bias     = {4'($urandom), $urandom};
        cfg_shift    = 5'($urandom);
        cfg_relu     = 1'($urandom);
        job_accepts  = 0;
        to = 0;
        for (int k = 0; k < vecs.size(); k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = vecs[k];
            waited   = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                waited++;
                if (waited > 300) begin
                    to = 1;
                    break;
                end
            end
            if (to) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_in_ready_timeout: got in_ready=0 for 300 cycles, expected 1", tag);
                break;
            end
            @(posedge clk); #1;
            job_accepts++;
            in_valid = 1'b0;
            if (midstart && k == 0) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        wait_done(tag);
    endtask

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: got no completion, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [IW-1:0] v;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_tree_data_zero", tree_data == '0, 1);
        reset = 1'b1;

        // Basic job with latency checks; out_ready held low until the result is seen.
        @(posedge clk); #1;
        cfg_channels = 1; cfg_pixels = 1; cfg_bias = '0; cfg_shift = 0; cfg_relu = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int l = 0; l < COL; l++) v[l*MW +: MW] = 32'd1;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        check("basic_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("basic_tree_data", tree_data == v, 1);
        @(posedge clk); #1;
        check("basic_lat1_valid", out_valid, 0);
        @(posedge clk); #1;
        check("basic_lat2_valid", out_valid, 1);
        check("basic_data", longint'($signed(out_data)), 9);
        exp_q.push_back(9);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("basic_done", done, 1);
        check("basic_busy", busy, 1);
        @(posedge clk); #1;
        check("basic_done_fall", done, 0);
        check("basic_busy_fall", busy, 0);
        check("basic_all_outputs", exp_q.size(), 0);

        run_job("chacc", 4, 1, -600, 2, 0, 0, 100, 0);
        run_job("sat", 1, 1, 0, 0, 0, 0, 32'h7FFF_0000, 0);
        run_job("relu_on", 1, 1, 0, 0, 1, 0, -5, 0);
        run_job("relu_off", 1, 1, 0, 0, 0, 0, -5, 0);
        run_job("midstart", 3, 3, 1234, 3, 0, 1, 0, 1);

        // Backpressure: FIFO fills to 2, further vectors are held.
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            run_job("bp", 1, 5, 0, 10, 0, 1, 0, 0);
            begin
                repeat (14) @(negedge clk);
                check("bp_accepts", job_accepts, 2);
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join

        // Degenerate configurations: immediate done, nothing produced.
        for (int d = 0; d < 2; d++) begin
            @(posedge clk); #1;
            cfg_channels = (d == 0) ? 8'd3 : 8'd0;
            cfg_pixels   = (d == 0) ? 16'd0 : 16'd2;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("degen_done", done, 1);
            check("degen_busy", busy, 1);
            @(negedge clk);
            check("degen_in_ready", in_ready, 0);
            @(negedge clk);
            check("degen_done_fall", done, 0);
            check("degen_in_ready2", in_ready, 0);
            check("degen_out_valid", out_valid, 0);
        end

        // Reset with two pixel-final vectors in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        cfg_channels = 1; cfg_pixels = 4; cfg_bias = '0; cfg_shift = 0; cfg_relu = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = {COL{32'd7}};
        @(negedge clk);
        check("rstmid_ready0", in_ready, 1);
        @(posedge clk); #1;
        in_data = {COL{32'd11}};
        @(negedge clk);
        check("rstmid_ready1", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_in_ready", in_ready, 0);
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_data", out_data, 0);
        check("rstmid_tree_data_zero", tree_data == '0, 1);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_no_push", out_valid, 0);
        out_ready = 1'b1;
        run_job("after_rst", 2, 3, -77, 1, 0, 1, 0, 0);

        // Randomized jobs under random consumer backpressure.
        fork
            begin
                for (int j = 0; j < 10; j++)
                    run_job("rnd", $urandom_range(1, 6), $urandom_range(1, 6),
                            longint'($urandom_range(0, 1 << 25)) - (1 << 24),
                            $urandom_range(0, 24), 1'($urandom_range(0, 1)), 1, 0,
                            1'($urandom_range(0, 1)));
                rnd_stop = 1;
            end
            begin
                while (!rnd_stop) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
